pio_input_conditioner: RTL

Fabric-side producer for the button and DIP-switch PIO inputs of the soc_system HPS subsystem.
- Synchronises the raw board KEY and SW pins to clk_clk, debounces each bit, and drives clean levels onto button_pio_external_connection_export and dipsw_pio_external_connection_export.
- Also produces per-button press/release pulses, a switch-change pulse and sticky per-button capture flags for the RISC-V/fabric logic that shares the board inputs.

---
 rtl/pio_input_conditioner.sv | 120 ++++++++++++
 1 files changed

// File: rtl/pio_input_conditioner.sv
// Board KEY/SW input conditioner.
// Each raw pin is normalised, passed through a two-flop synchroniser and then
// debounced. The block also produces press/release pulses, a switch-change
// pulse and sticky press-capture flags.

// One debounced input bit: a 2-flop synchroniser followed by a stable-time counter.
module pio_db_lane #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic din_i,     // normalised raw level; asynchronous to clk_i
  output logic stable_o,  // debounced level
  output logic upd_o      // stable_o toggles on the coming edge
);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s2_q, stable_q, stable_d, upd;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter runs only while s2 disagrees with the stable level.
  // Any agreement restarts the stable-time count.
  always_comb begin
    cnt_d = '0;
    upd   = 1'b0;
    if (s2_q != stable_q) begin
      if (cnt_q == TERM) upd = 1'b1;
      else               cnt_d = cnt_q + CNT_W'(1);
    end
    stable_d = stable_q ^ upd;
  end

  // Synchroniser, counter and stable-level registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      s1_q     <= din_i;
      s2_q     <= s1_q;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o = stable_q;
  assign upd_o    = upd;
endmodule

module pio_input_conditioner #(
  parameter int N_BTN           = 4,
  parameter int N_SW            = 10,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BTN_ACTIVE_LOW  = 1,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  input  logic [N_BTN-1:0] key_raw_i,
  input  logic [N_SW-1:0]  sw_raw_i,
  input  logic [N_BTN-1:0] capture_clr_i,
  output logic [N_BTN-1:0] button_pio_external_connection_export,
  output logic [N_SW-1:0]  dipsw_pio_external_connection_export,
  output logic [N_BTN-1:0] btn_press_o,
  output logic [N_BTN-1:0] btn_release_o,
  output logic             sw_change_o,
  output logic [N_BTN-1:0] btn_capture_o
);
  // Buttons are inverted ahead of the synchroniser, so that its reset value
  // of 0 means "released".
  logic [N_BTN-1:0] key_n, btn_stable, btn_upd;
  logic [N_SW-1:0]  sw_stable, sw_upd;

  assign key_n = (BTN_ACTIVE_LOW != 0) ? ~key_raw_i : key_raw_i;

  pio_db_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_btn [N_BTN-1:0] (
    .clk_i(clk_clk), .rst_i(reset_reset), .din_i(key_n),
    .stable_o(btn_stable), .upd_o(btn_upd));

  pio_db_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_sw [N_SW-1:0] (
    .clk_i(clk_clk), .rst_i(reset_reset), .din_i(sw_raw_i),
    .stable_o(sw_stable), .upd_o(sw_upd));

  logic [N_BTN-1:0] press_q, press_d, release_q, release_d, cap_q, cap_d;
  logic             chg_q, chg_d;

  // Edge pulses register on the same edge as the stable update.
  // A capture set takes priority over a clear arriving in the same cycle.
  always_comb begin
    press_d   = btn_upd & ~btn_stable;
    release_d = btn_upd &  btn_stable;
    chg_d     = |sw_upd;
    cap_d     = press_d | (cap_q & ~capture_clr_i);
  end

  // Pulse and capture registers.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      press_q   <= '0;
      release_q <= '0;
      chg_q     <= 1'b0;
      cap_q     <= '0;
    end else begin
      press_q   <= press_d;
      release_q <= release_d;
      chg_q     <= chg_d;
      cap_q     <= cap_d;
    end
  end

  assign button_pio_external_connection_export = btn_stable;
  assign dipsw_pio_external_connection_export  = sw_stable;
  assign btn_press_o   = press_q;
  assign btn_release_o = release_q;
  assign sw_change_o   = chg_q;
  assign btn_capture_o = cap_q;
endmodule
